and_chunk_sequencer: RTL and testbench

Multi-cycle AND-reduction controller that time-multiplexes one LENGTH-wide AND-chain datapath over a wide input word of LENGTH*CHUNKS bits. The block captures the word on a start request and feeds it through the shared chain one chunk per clock. It accumulates the partial results and reports the final AND with a one-cycle done pulse. It sits between a requesting host FSM and the parameterized AND-chain, replacing a LENGTH*CHUNKS-wide combinational gate when area or path length matters.

---
 rtl/and_chunk_sequencer.sv | 138 +++++++++++++
 tb/tb_and_chunk_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/and_chunk_sequencer.sv
// Multi-cycle AND reduction: one LENGTH-wide AND chain is reused over CHUNKS chunks of a captured word.
// Optional build macro AND_SEQ_EARLY_EXIT_EN: finish as soon as a chunk containing a 0 is seen.

module and_chunk_sequencer_chain #(
    parameter int LENGTH = 8
) (
    input  logic [LENGTH-1:0] i_bits,
    output logic              o_and
);
    logic [LENGTH:0] w_chain;

    assign w_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < LENGTH; gi++) begin : g_chain
            assign w_chain[gi+1] = w_chain[gi] & i_bits[gi];
        end
    endgenerate

    assign o_and = w_chain[LENGTH];
endmodule

module and_chunk_sequencer #(
    parameter int LENGTH = 8,
    parameter int CHUNKS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LENGTH*CHUNKS-1:0]     data_in,
    output logic                         busy,
    output logic                         done,
    output logic                         result,
    output logic [$clog2(CHUNKS+1)-1:0]  fail_idx
);
    localparam int W  = LENGTH * CHUNKS;
    localparam int CW = $clog2(CHUNKS);
    localparam int FW = $clog2(CHUNKS + 1);
    localparam logic [FW-1:0] FIDX_NONE = FW'(CHUNKS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_sreg;
    logic            r_acc;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_fidx;
    logic            r_result;
    logic [FW-1:0]   r_fail_idx;

    logic            w_chunk_and;
    logic            w_acc_new;
    logic [FW-1:0]   w_fidx_new;
    logic            w_last;
    logic            w_exit;

    and_chunk_sequencer_chain #(
        .LENGTH (LENGTH)
    ) u_chain (
        .i_bits (r_sreg[LENGTH-1:0]),
        .o_and  (w_chunk_and)
    );

    assign w_acc_new  = r_acc & w_chunk_and;
    // Only the first failing chunk is recorded; later failures leave fidx alone.
    assign w_fidx_new = (!w_chunk_and && (r_fidx == FIDX_NONE)) ? FW'(r_cnt) : r_fidx;
    assign w_last     = (r_cnt == CNT_LAST);

`ifdef AND_SEQ_EARLY_EXIT_EN
    assign w_exit = w_last || !w_chunk_and;
`else
    assign w_exit = w_last;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_exit) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg     <= '0;
            r_acc      <= 1'b1;
            r_cnt      <= '0;
            r_fidx     <= '0;
            r_result   <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sreg <= data_in;
                        r_acc  <= 1'b1;
                        r_cnt  <= '0;
                        r_fidx <= FIDX_NONE;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_new;
                    r_fidx <= w_fidx_new;
                    r_sreg <= r_sreg >> LENGTH;
                    // Counter holds on the terminal chunk so it never wraps.
                    if (w_exit) begin
                        r_result   <= w_acc_new;
                        r_fail_idx <= w_fidx_new;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign fail_idx = r_fail_idx;
endmodule

// File: tb/tb_and_chunk_sequencer.sv
// Directed bench for and_chunk_sequencer (LENGTH=8, CHUNKS=4); latency expectations follow AND_SEQ_EARLY_EXIT_EN.

module tb_and_chunk_sequencer;
`ifdef AND_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        result;
    logic [2:0]  fail_idx;

    int n_checks = 0;
    int n_fail   = 0;

    and_chunk_sequencer #(
        .LENGTH (8),
        .CHUNKS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .fail_idx (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from IDLE; data_in is zeroed right after capture.
    task automatic run_op(input logic [31:0] d, input logic exp_res,
                          input logic [2:0] exp_fidx, input int exp_lat);
        int lat;
        int busy_cyc;
        lat      = 99;
        busy_cyc = 0;
        start    = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = 32'h0;
        check("busy_after_capture", {31'b0, busy}, 32'd1);
        if (busy) busy_cyc++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("result", {31'b0, result}, {31'b0, exp_res});
        check("fail_idx", {29'b0, fail_idx}, {29'b0, exp_fidx});
        check("busy_cycles", busy_cyc, exp_lat + 1);
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("busy_low_after", {31'b0, busy}, 32'd0);
        $display("op data=%h result=%0d fail_idx=%0d latency=%0d busy_cycles=%0d",
                 d, result, fail_idx, lat, busy_cyc);
    endtask

    initial begin
        logic [31:0] done_mask;
        logic [31:0] idle_mask;
        logic        saw_done;

        rst     = 1'b1;
        start   = 1'b0;
        data_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", {31'b0, result}, 32'd0);
        check("reset_fail_idx", {29'b0, fail_idx}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 1'b1, 3'd4, 4);
        run_op(32'hFFFF_FEFF, 1'b0, 3'd1, EARLY ? 2 : 4);
        run_op(32'h7FFF_FFFF, 1'b0, 3'd3, 4);
        run_op(32'h0000_0000, 1'b0, 3'd0, EARLY ? 1 : 4);
        run_op(32'h007F_FFFF, 1'b0, 3'd2, EARLY ? 3 : 4);

        repeat (3) @(posedge clk);
        #1;
        check("result_held", {31'b0, result}, 32'd0);
        check("fail_idx_held", {29'b0, fail_idx}, 32'd2);
        run_op(32'hFFFF_FFFF, 1'b1, 3'd4, 4);

        // start held high: captures at edges 1, 7, 13 -> done after 5, 11, 17; idle after 6, 12, 18
        start     = 1'b1;
        data_in   = 32'hFFFF_FFFF;
        done_mask = '0;
        idle_mask = '0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            done_mask[k] = done;
            idle_mask[k] = ~busy;
        end
        start = 1'b0;
        check("held_start_done_mask", done_mask, 32'h0002_0820);
        check("held_start_idle_mask", idle_mask, 32'h0004_1040);
        check("held_start_result", {31'b0, result}, 32'd1);
        $display("op held_start done_mask=%h idle_mask=%h", done_mask, idle_mask);

        // Reset sampled during the second RUN cycle discards the operation.
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_busy", {31'b0, busy}, 32'd0);
        check("midrun_rst_done", {31'b0, done}, 32'd0);
        check("midrun_rst_result", {31'b0, result}, 32'd0);
        check("midrun_rst_fail_idx", {29'b0, fail_idx}, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midrun_rst_no_done", {31'b0, saw_done}, 32'd0);
        $display("op midrun_reset busy=%0d result=%0d fail_idx=%0d", busy, result, fail_idx);

        // rst wins over start at the same edge.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_over_start_busy", {31'b0, busy}, 32'd0);
        $display("op rst_with_start busy=%0d", busy);

        run_op(32'hFFFF_FFFF, 1'b1, 3'd4, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
